// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I load/store bus port with wait states, lane steering and timeout.
// Build option: MISALIGN_TRAP_EN turns misaligned half/word accesses into err responses.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_FAULT, S_RESP} state_t;

    localparam logic [31:0] TMAX = 32'(TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] timer_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        fault_d;
    logic [1:0]  off_d;
    logic [3:0]  strb_d;
    logic [31:0] wdat_d;
    logic [31:0] load_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Request decode: legality, effective lane offset, strobes and replicated store data.
    always_comb begin
        fault_d = 1'b0;
        off_d   = addr[1:0];
        strb_d  = 4'b0000;
        wdat_d  = wdata;
        case (funct3)
            3'b000: begin
                strb_d = 4'b0001 << addr[1:0];
                wdat_d = {4{wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                off_d   = {addr[1], 1'b0};
                strb_d  = addr[1] ? 4'b1100 : 4'b0011;
                wdat_d  = {2{wdata[15:0]}};
                fault_d = funct3[2] & mem_we;
            end
            3'b100: fault_d = mem_we;
            3'b010: begin
                off_d  = 2'b00;
                strb_d = 4'b1111;
            end
            default: fault_d = 1'b1;
        endcase
`ifdef MISALIGN_TRAP_EN
        if ((funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00))
            fault_d = 1'b1;
`endif
    end

    // Load extraction from the raw bus word using the captured size and offset.
    always_comb begin
        byte_sel = bus_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_d = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
            2'b01:   load_d = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
            default: load_d = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_req) begin
                        busy     <= 1'b1;
                        funct3_q <= funct3;
                        off_q    <= off_d;
                        timer_q  <= '0;
                        if (fault_d) begin
                            state_q <= S_FAULT;
                        end else begin
                            state_q   <= S_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_we;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wstrb <= mem_we ? strb_d : 4'b0000;
                            bus_wdata <= mem_we ? wdat_d : 32'h0;
                        end
                    end
                end
                S_BUS: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (bus_ack || (TIMEOUT != 0 && timer_q == TMAX)) begin
                        state_q   <= S_RESP;
                        done      <= 1'b1;
                        err       <= ~bus_ack;
                        rdata     <= (bus_ack && !bus_we) ? load_d : 32'h0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wstrb <= '0;
                        bus_wdata <= '0;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                S_FAULT: begin
                    state_q <= S_RESP;
                    done    <= 1'b1;
                    err     <= 1'b1;
                    rdata   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    err     <= 1'b0;
                    rdata   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        done, busy, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;
    int cnt;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic ack_after(input int n, input logic [31:0] rd);
        repeat (n) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = rd;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic resp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
        chk({tag, ".done"}, {31'h0, done}, 32'h1);
        chk({tag, ".rdata"}, rdata, exp_rdata);
        chk({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
        chk({tag, ".busy"}, {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk({tag, ".done_clr"}, {31'h0, done}, 32'h0);
        chk({tag, ".busy_clr"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst.busy", {31'h0, busy}, 32'h0);
        chk("rst.done", {31'h0, done}, 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // lw 0x100, three wait cycles; a request while busy must be dropped
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw.bus_req", {31'h0, bus_req}, 32'h1);
        chk("lw.bus_addr", bus_addr, 32'h100);
        chk("lw.wstrb", {28'h0, bus_wstrb}, 32'h0);
        chk("lw.bus_we", {31'h0, bus_we}, 32'h0);
        mem_req = 1'b1; funct3 = 3'b010; addr = 32'h999;
        @(negedge clk);
        mem_req = 1'b0; addr = 32'h0;
        chk("lw.addr_hold", bus_addr, 32'h100);
        repeat (2) @(negedge clk);
        chk("lw.wait_done", {31'h0, done}, 32'h0);
        ack_after(0, 32'hDEADBEEF);
        resp("lw", 32'hDEADBEEF, 1'b0);
        chk("lw.no_requeue", {31'h0, bus_req}, 32'h0);

        issue(1'b0, 3'b000, 32'h203, 32'h0);
        chk("lb.bus_addr", bus_addr, 32'h200);
        ack_after(0, 32'h80FF_1234);
        resp("lb", 32'hFFFFFF80, 1'b0);

        issue(1'b0, 3'b100, 32'h203, 32'h0);
        ack_after(0, 32'h80FF_1234);
        resp("lbu", 32'h00000080, 1'b0);

        issue(1'b0, 3'b001, 32'h302, 32'h0);
        ack_after(1, 32'h8001_0000);
        resp("lh", 32'hFFFF8001, 1'b0);

        issue(1'b0, 3'b101, 32'h300, 32'h0);
        ack_after(0, 32'h1234_9ABC);
        resp("lhu", 32'h00009ABC, 1'b0);

        issue(1'b1, 3'b001, 32'h302, 32'h0000ABCD);
        chk("sh.wstrb", {28'h0, bus_wstrb}, 32'hC);
        chk("sh.wdata", bus_wdata, 32'hABCDABCD);
        chk("sh.bus_we", {31'h0, bus_we}, 32'h1);
        chk("sh.bus_addr", bus_addr, 32'h300);
        ack_after(0, 32'hFFFFFFFF);
        resp("sh", 32'h0, 1'b0);

        issue(1'b1, 3'b000, 32'h301, 32'h12345677);
        chk("sb.wstrb", {28'h0, bus_wstrb}, 32'h2);
        chk("sb.wdata", bus_wdata, 32'h77777777);
        ack_after(0, 32'h0);
        resp("sb", 32'h0, 1'b0);

        issue(1'b1, 3'b010, 32'h308, 32'hCAFEF00D);
        chk("sw.wstrb", {28'h0, bus_wstrb}, 32'hF);
        chk("sw.wdata", bus_wdata, 32'hCAFEF00D);
        ack_after(0, 32'h0);
        resp("sw", 32'h0, 1'b0);

        // Timeout with no ack: bus_req held exactly 16 cycles
        bus_rdata = 32'h5555AAAA;
        issue(1'b0, 3'b010, 32'h600, 32'h0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus_req) cnt++;
            @(negedge clk);
        end
        chk("to.req_cycles", 32'(cnt), 32'd16);
        chk("to.req_drop", {31'h0, bus_req}, 32'h0);
        resp("to", 32'h0, 1'b1);

        issue(1'b0, 3'b010, 32'h604, 32'h0);
        ack_after(15, 32'h12345678);
        resp("to_ack16", 32'h12345678, 1'b0);

        issue(1'b0, 3'b011, 32'h700, 32'h0);
        chk("ill.bus_req", {31'h0, bus_req}, 32'h0);
        chk("ill.busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        resp("ill", 32'h0, 1'b1);

        issue(1'b1, 3'b100, 32'h700, 32'h11);
        chk("sbu.bus_req", {31'h0, bus_req}, 32'h0);
        @(negedge clk);
        resp("sbu", 32'h0, 1'b1);

        issue(1'b0, 3'b010, 32'h401, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("mis.bus_req", {31'h0, bus_req}, 32'h0);
        @(negedge clk);
        chk("mis.bus_req2", {31'h0, bus_req}, 32'h0);
        resp("mis", 32'h0, 1'b1);
`else
        chk("mis.bus_addr", bus_addr, 32'h400);
        chk("mis.bus_req", {31'h0, bus_req}, 32'h1);
        ack_after(0, 32'h01020304);
        resp("mis", 32'h01020304, 1'b0);
`endif

        // Reset while in BUS: outputs drop at once, no done afterwards
        issue(1'b0, 3'b010, 32'h800, 32'h0);
        chk("rstb.pre_req", {31'h0, bus_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rstb.bus_req", {31'h0, bus_req}, 32'h0);
        chk("rstb.busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || bus_req) cnt++;
        end
        chk("rstb.no_done", 32'(cnt), 32'd0);
        issue(1'b0, 3'b010, 32'h900, 32'h0);
        chk("rstb.new_addr", bus_addr, 32'h900);
        ack_after(0, 32'hA5A5A5A5);
        resp("rstb.new", 32'hA5A5A5A5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
